// File: rtl/mat_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mat_stream_loader
//  Description : Serial-to-parallel matrix assembler. Accepts one element per
//                valid/ready handshake in row-major order and captures the
//                scale factor with element [0][0]. When the last element is
//                accepted, it holds the full matrix and scale stable until
//                the consumer acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_stream_loader #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 22
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     clear,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [N_BITS-1:0]                        in_data,
    input  logic [N_BITS-1:0]                        scale_in,
    output logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0] mat,
    output logic [N_BITS-1:0]                        scale_out,
    output logic                                     mat_valid,
    input  logic                                     mat_ack
);

    // Counter widths; a size-1 dimension still gets a 1-bit counter.
    localparam int c_row_w = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int c_col_w = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(SIZE_A - 1);
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(SIZE_B - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                                     r_state;
    logic [c_row_w-1:0]                         r_row;
    logic [c_col_w-1:0]                         r_col;
    logic                                       r_in_ready;
    logic                                       r_mat_valid;
    logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0]  r_mat;
    logic [N_BITS-1:0]                          r_scale;

    logic                                       w_accept;
    logic                                       w_first;

    // An element is taken only while filling; clear suppresses the write.
    assign w_accept = (r_state == FILL) && in_valid && !clear;
    assign w_first  = (r_row == '0) && (r_col == '0);

    assign in_ready  = r_in_ready;
    assign mat_valid = r_mat_valid;
    assign mat       = r_mat;
    assign scale_out = r_scale;

    // Fill/full sequencing with row-major index counters and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FILL;
            r_row       <= '0;
            r_col       <= '0;
            r_in_ready  <= 1'b1;
            r_mat_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (clear) begin
                        // Abandon the partial fill; stale data is overwritten on refill.
                        r_row <= '0;
                        r_col <= '0;
                    end else if (in_valid) begin
                        if (r_col == c_last_col) begin
                            r_col <= '0;
                            if (r_row == c_last_row) begin
                                r_row       <= '0;
                                r_state     <= FULL;
                                r_in_ready  <= 1'b0;
                                r_mat_valid <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // clear in FULL behaves exactly like an acknowledge.
                    if (mat_ack || clear) begin
                        r_state     <= FILL;
                        r_in_ready  <= 1'b1;
                        r_mat_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_row       <= '0;
                    r_col       <= '0;
                    r_in_ready  <= 1'b1;
                    r_mat_valid <= 1'b0;
                end
            endcase
        end
    end

    // Element storage: write the accepted element at the current row/col.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mat <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < SIZE_A; r++) begin
                for (int c = 0; c < SIZE_B; c++) begin
                    if ((r_row == c_row_w'(r)) && (r_col == c_col_w'(c))) begin
                        r_mat[r][c] <= in_data;
                    end
                end
            end
        end
    end

    // Scale is captured only alongside element [0][0].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scale <= '0;
        end else if (w_accept && w_first) begin
            r_scale <= scale_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mat_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_stream_loader
//  Description : Self-checking bench for mat_stream_loader (2x3 and 1x1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_stream_loader;

    localparam int A = 2;
    localparam int B = 3;
    localparam int W = 22;

    logic clk = 1'b0;
    logic reset, clear, in_valid, in_ready, mat_valid, mat_ack;
    logic [W-1:0] in_data, scale_in, scale_out;
    logic [A-1:0][B-1:0][W-1:0] mat;

    logic clear1, in_valid1, in_ready1, mat_valid1, mat_ack1;
    logic [W-1:0] in_data1, scale_in1, scale_out1;
    logic [0:0][0:0][W-1:0] mat1;

    int n_assert = 0;
    int n_fail   = 0;
    int m_cnt    = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] scale_q[$];
    logic [W-1:0] last_mat[A][B];
    logic [W-1:0] last_scale;

    always #5 clk = ~clk;

    mat_stream_loader #(.SIZE_A(A), .SIZE_B(B), .N_BITS(W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .scale_in(scale_in),
        .mat(mat), .scale_out(scale_out), .mat_valid(mat_valid), .mat_ack(mat_ack)
    );

    mat_stream_loader #(.SIZE_A(1), .SIZE_B(1), .N_BITS(W)) dut1 (
        .clk(clk), .reset(reset), .clear(clear1), .in_valid(in_valid1),
        .in_ready(in_ready1), .in_data(in_data1), .scale_in(scale_in1),
        .mat(mat1), .scale_out(scale_out1), .mat_valid(mat_valid1), .mat_ack(mat_ack1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted beat; the model pushes the expected element/scale.
    task automatic send_beat(input logic [W-1:0] d, input logic [W-1:0] s);
        chk("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        scale_in = s;
        if (m_cnt == 0) scale_q.push_back(s);
        exp_q.push_back(d);
        m_cnt++;
        step();
        in_valid = 1'b0;
        if (m_cnt == A * B) begin
            m_cnt = 0;
            chk("mat_valid_after_last", {31'd0, mat_valid}, 32'd1);
            chk("in_ready_when_full", {31'd0, in_ready}, 32'd0);
        end else begin
            chk("mat_valid_mid_fill", {31'd0, mat_valid}, 32'd0);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    // Pop the expected matrix from the scoreboard and compare it.
    task automatic check_matrix();
        n_assert++;
        assert (exp_q.size() >= A * B && scale_q.size() >= 1) else begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%0d expected=%0d", exp_q.size(), A * B);
        end
        if (exp_q.size() >= A * B && scale_q.size() >= 1) begin
            for (int r = 0; r < A; r++) begin
                for (int c = 0; c < B; c++) begin
                    last_mat[r][c] = exp_q.pop_front();
                    chk($sformatf("mat[%0d][%0d]", r, c), {10'd0, mat[r][c]}, {10'd0, last_mat[r][c]});
                end
            end
            last_scale = scale_q.pop_front();
            chk("scale_out", {10'd0, scale_out}, {10'd0, last_scale});
        end
    endtask

    task automatic check_held();
        for (int r = 0; r < A; r++)
            for (int c = 0; c < B; c++)
                chk($sformatf("held_mat[%0d][%0d]", r, c), {10'd0, mat[r][c]}, {10'd0, last_mat[r][c]});
        chk("held_scale", {10'd0, scale_out}, {10'd0, last_scale});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mat_valid"}, {31'd0, mat_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_scale"}, {10'd0, scale_out}, 32'd0);
        chk({tag, "_mat"}, {31'd0, (mat == '0)}, 32'd1);
    endtask

    task automatic flush_model();
        exp_q.delete();
        scale_q.delete();
        m_cnt = 0;
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        step();
        mat_ack = 1'b0;
        chk("mat_valid_after_ack", {31'd0, mat_valid}, 32'd0);
        chk("in_ready_after_ack", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mat_ack = 1'b0;
        in_data = '0; scale_in = '0;
        clear1 = 1'b0; in_valid1 = 1'b0; mat_ack1 = 1'b0;
        in_data1 = '0; scale_in1 = '0;
        step();
        step();
        check_reset_state("reset");
        chk("reset_1x1_valid", {31'd0, mat_valid1}, 32'd0);
        chk("reset_1x1_ready", {31'd0, in_ready1}, 32'd1);
        reset = 1'b0;
        step();

        // Matrix 1: continuous stream 1..6, scale 5 on first beat then 9.
        for (int i = 1; i <= 6; i++) send_beat(W'(i), (i == 1) ? W'(5) : W'(9));
        check_matrix();

        // Hold FULL for 20 cycles with in_valid=1 and data 77.
        in_valid = 1'b1;
        in_data  = W'(77);
        scale_in = W'(33);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_mat_valid", {31'd0, mat_valid}, 32'd1);
        end
        in_valid = 1'b0;
        check_held();
        ack();

        // Matrix 2: immediate restart with gaps and a stray ack in FILL.
        for (int i = 11; i <= 16; i++) begin
            send_beat(W'(i), (i == 11) ? W'(31) : W'(40));
            if (i == 13) mat_ack = 1'b1;
            if (i < 16) idle();
            mat_ack = 1'b0;
        end
        check_matrix();
        ack();

        // Clear after 4 accepts; the 99 presented alongside must not land.
        for (int i = 41; i <= 44; i++) send_beat(W'(i), W'(3));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = W'(99);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        flush_model();
        chk("mat_valid_after_clear", {31'd0, mat_valid}, 32'd0);
        for (int i = 21; i <= 26; i++) send_beat(W'(i), (i == 21) ? W'(7) : W'(8));
        check_matrix();

        // clear in FULL acts as an acknowledge.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_full_valid", {31'd0, mat_valid}, 32'd0);
        chk("clear_full_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-fill.
        for (int i = 51; i <= 53; i++) send_beat(W'(i), W'(2));
        reset = 1'b1;
        step();
        reset = 1'b0;
        flush_model();
        check_reset_state("reset_mid_fill");
        for (int i = 61; i <= 66; i++) send_beat(W'(i), (i == 61) ? W'(12) : W'(13));
        check_matrix();

        // Reset while FULL.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("reset_full");
        for (int i = 71; i <= 76; i++) send_beat(W'(i), (i == 71) ? W'(14) : W'(15));
        check_matrix();

        // clear and ack together act as a single ack.
        clear   = 1'b1;
        mat_ack = 1'b1;
        step();
        clear   = 1'b0;
        mat_ack = 1'b0;
        chk("clear_ack_valid", {31'd0, mat_valid}, 32'd0);
        chk("clear_ack_ready", {31'd0, in_ready}, 32'd1);

        // 1x1 instance: a single accept goes straight to FULL.
        in_valid1 = 1'b1;
        in_data1  = 22'h3FFFFF;
        scale_in1 = 22'h200000;
        step();
        in_valid1 = 1'b0;
        chk("1x1_valid", {31'd0, mat_valid1}, 32'd1);
        chk("1x1_ready", {31'd0, in_ready1}, 32'd0);
        chk("1x1_mat", {10'd0, mat1[0][0]}, 32'h003FFFFF);
        chk("1x1_scale", {10'd0, scale_out1}, 32'h00200000);
        mat_ack1 = 1'b1;
        step();
        mat_ack1 = 1'b0;
        chk("1x1_valid_after_ack", {31'd0, mat_valid1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat_stream_loader.md
Name: mat_stream_loader

Overview:
- Serial-to-parallel matrix assembler placed directly upstream of the combinational scalar-matrix multiplier.
- Accepts one N_BITS matrix element per handshake, in row-major order, and captures the scale factor together with element [0][0].
- Once all SIZE_A*SIZE_B elements are loaded, presents the complete matrix and scale, held stable, until the consumer acknowledges.

Parameters:
SIZE_A, 8, number of rows
SIZE_B, 8, number of columns
N_BITS, 22, element and scale width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  abort the current fill; takes effect on the next edge
in_valid  in  1  in_data (and scale_in when loading [0][0]) is valid
in_ready  out  1  loader can accept an element this cycle
in_data  in  N_BITS  matrix element, row-major order
scale_in  in  N_BITS  scale factor, sampled only on acceptance of element [0][0]
mat  out  N_BITS x [SIZE_A][SIZE_B]  assembled matrix, wired to multiplier mat
scale_out  out  N_BITS  captured scale, wired to multiplier scale
mat_valid  out  1  mat and scale_out are complete and stable
mat_ack  in  1  consumer has taken the matrix

Behaviour:
- States: FILL and FULL.
- Reset (synchronous, active-high):
  - state=FILL, row=0, col=0.
  - mat all zeros, scale_out=0, mat_valid=0.
- Outputs in each state:
  - in_ready=1 in FILL, 0 in FULL; in_ready is a registered-state decode with no combinational path from in_valid.
  - mat_valid=1 exactly while in FULL.
- Acceptance rule: an element is accepted on a rising edge with in_valid && in_ready. Only then:
  - mat[row][col] <= in_data.
  - If row==0 && col==0, also scale_out <= scale_in.
- Indexing:
  - col increments on each accept.
  - At col==SIZE_B-1, col wraps to 0 and row increments.
  - Accepting [SIZE_A-1][SIZE_B-1] sets row=col=0 and moves to FULL. mat_valid rises in the cycle after the last accept, so latency is SIZE_A*SIZE_B accepted beats plus 1 cycle.
- In FULL:
  - mat and scale_out do not change; in_valid is ignored.
  - mat_ack=1 returns to FILL on the next edge, so mat_valid drops that edge.
  - mat_ack held low keeps FULL indefinitely.
  - mat and scale_out keep their old values after ack until overwritten element by element. The consumer must not use them while mat_valid=0.
- Back-to-back operation: the first element of the next matrix can be accepted in the cycle after the ack edge. There is one bubble cycle per matrix.
- mat_ack while in FILL is ignored.
- clear:
  - In FILL: row=col=0 and the partial data is discarded (stale contents are retained but are overwritten on refill). An element presented in the same cycle as clear is not written.
  - In FULL: acts as ack. Returns to FILL and mat_valid drops.
  - clear and mat_ack together behave as a single ack.
- reset has priority over clear, and clear has priority over a data accept.
- Arithmetic: data is stored bit-exact, with no sign extension or truncation.
- Counters: row is $clog2(SIZE_A) bits and col is $clog2(SIZE_B) bits, minimum 1 bit each. Size-1 dimensions must work; 1x1 means every accept goes straight to FULL.
- Reset mid-fill or in FULL: immediate return to the reset state on that edge, with no partial output.

Test Plan:
- SIZE_A=2, SIZE_B=3: stream 1..6 continuously with scale_in=5 on the first beat and 9 afterwards → mat_valid rises on the cycle after beat 6; mat={{1,2,3},{4,5,6}}; scale_out=5; in_ready=0 while mat_valid=1.
- Hold mat_ack=0 for 20 cycles with in_valid=1 and in_data=77 → mat and scale_out unchanged; mat_valid stays 1. Then pulse mat_ack for 1 cycle → mat_valid=0 and in_ready=1 on the next cycle.
- Ack, then immediately stream 11..16 with gaps (in_valid toggling) → second matrix {{11,12,13},{14,15,16}} is correct and scale_out is the value sampled on the 11 beat.
- After 4 accepts, assert clear with in_valid=1 and in_data=99 → 99 is not written. Restream 21..26 → mat={{21,22,23},{24,25,26}} with no stale or shifted elements.
- Assert reset after 3 accepts, then again while in FULL → mat all 0, scale_out=0, mat_valid=0, in_ready=1 on the following cycle. The next 6 beats fill from [0][0].
- 1x1 configuration: a single accept of 0x3FFFFF with scale 0x200000 → mat[0][0]=0x3FFFFF, scale_out=0x200000, mat_valid=1 next cycle.
